// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and SPI mode constants.
package spi_pkg;

  typedef logic [2:0] spi_state_t;

  localparam spi_state_t ST_IDLE   = 3'd0;
  localparam spi_state_t ST_SETUP  = 3'd1;
  localparam spi_state_t ST_XFER   = 3'd2;
  localparam spi_state_t ST_HOLD   = 3'd3;
  localparam spi_state_t ST_FINISH = 3'd4;

  // mode is {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period tick generator: one-cycle tick every CLK_DIV enabled cycles.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter sits at zero while disabled so every phase starts a full half-period.
  always_comb begin
    cnt_d  = '0;
    tick_o = 1'b0;
    if (en_i) begin
      if (cnt_q == LAST) begin
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master with runtime mode, bit order and one-hot chip selects.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int NUM_CS     = 2,
  parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic [1:0]            mode,
  input  logic                  lsb_first,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_CS-1:0]     cs_n
);

  localparam int EW = $clog2(2 * DATA_WIDTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);
  localparam logic [31:0] NUM_CS_U = NUM_CS;

  spi_state_t            state_q, state_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic                  cpha_q, cpha_d;
  logic                  lsb_q, lsb_d;

  logic              tick;
  logic              gen_en;
  logic              accept;
  logic              cs_ok;
  logic              sample_edge;
  logic              last_edge;
  logic [NUM_CS-1:0] sel_n;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                      input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
      assign sel_n[gi] = (cs_sel != CS_W'(gi));
    end
  endgenerate

  assign cs_ok  = (32'(cs_sel) < NUM_CS_U);
  assign accept = (state_q == ST_IDLE) && start && cs_ok;
  assign gen_en = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);

  // Odd (leading) edges have an even edge index; CPHA flips which edge samples.
  assign sample_edge = (~edge_q[0]) ^ cpha_q;
  assign last_edge   = (edge_q == LAST_EDGE);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk   (clk),
    .rst_ni(rst),
    .en_i  (gen_en),
    .tick_o(tick)
  );

  always_comb begin
    state_d = state_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    cs_n_d  = cs_n_q;
    edge_d  = edge_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          cpha_d  = mode[CPHA_BIT];
          lsb_d   = lsb_first;
          sck_d   = mode[CPOL_BIT];
          cs_n_d  = sel_n;
          rx_d    = '0;
          edge_d  = '0;
          // CPHA=0 needs the first bit on the wire before the first sck edge.
          if (!mode[CPHA_BIT]) begin
            mosi_d = first_bit(data_in, lsb_first);
            tx_d   = shift_out(data_in, lsb_first);
          end else begin
            mosi_d = 1'b0;
            tx_d   = data_in;
          end
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (tick) begin
          sck_d = ~sck_q;
          if (sample_edge) begin
            rx_d = lsb_q ? {miso, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], miso};
          end else if (!last_edge) begin
            mosi_d = first_bit(tx_q, lsb_q);
            tx_d   = shift_out(tx_q, lsb_q);
          end
          if (last_edge) begin
            state_d = ST_HOLD;
            edge_d  = '0;
          end else begin
            edge_d = edge_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_FINISH;
          cs_n_d  = '1;
          dout_d  = rx_q;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      cs_n_q  <= '1;
      edge_q  <= '0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      cs_n_q  <= cs_n_d;
      edge_q  <= edge_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
    end
  end

  assign data_out = dout_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FINISH);
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench: 8-bit/div-2 master against a mode-aware slave model, plus a 16-bit/div-1 loopback.
module tb_spi_master_param;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 8-bit, CLK_DIV=2, two chip selects, wide cs_sel so out-of-range indices are expressible
  logic       start8 = 1'b0;
  logic [1:0] cs_sel8 = 2'd0;
  logic [1:0] mode8 = 2'b00;
  logic       lsb8 = 1'b0;
  logic [7:0] data_in8 = 8'h00;
  logic [7:0] data_out8;
  logic       busy8, done8, sck8, mosi8;
  logic       miso8 = 1'b0;
  logic [1:0] cs_n8;

  // 16-bit, CLK_DIV=1, mosi looped back to miso
  logic        start16 = 1'b0;
  logic        cs_sel16 = 1'b0;
  logic [1:0]  mode16 = 2'b00;
  logic        lsb16 = 1'b0;
  logic [15:0] data_in16 = 16'h0000;
  logic [15:0] data_out16;
  logic        busy16, done16, sck16, mosi16;
  logic [1:0]  cs_n16;

  int total = 0;
  int bad = 0;

  spi_master_param #(.DATA_WIDTH(8), .CLK_DIV(2), .NUM_CS(2), .CS_W(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .cs_sel(cs_sel8), .mode(mode8),
    .lsb_first(lsb8), .data_in(data_in8), .data_out(data_out8), .busy(busy8),
    .done(done8), .sck(sck8), .mosi(mosi8), .miso(miso8), .cs_n(cs_n8)
  );

  spi_master_param #(.DATA_WIDTH(16), .CLK_DIV(1), .NUM_CS(2)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .cs_sel(cs_sel16), .mode(mode16),
    .lsb_first(lsb16), .data_in(data_in16), .data_out(data_out16), .busy(busy16),
    .done(done16), .sck(sck16), .mosi(mosi16), .miso(mosi16), .cs_n(cs_n16)
  );

  // Slave model: sends s_cfg_tx from bit 7 down, records mosi into s_seq in wire order.
  logic [7:0] s_cfg_tx = 8'h00;
  logic [1:0] s_cfg_mode = 2'b00;
  logic [7:0] s_tx = 8'h00;
  logic [7:0] s_seq = 8'h00;
  logic       s_cpha = 1'b0;
  logic       s_active = 1'b0;
  logic       s_prev_sck = 1'b0;
  int         s_edges = 0;

  always @(negedge clk) begin
    if (cs_n8 == 2'b11) begin
      s_active = 1'b0;
    end else if (!s_active) begin
      s_active   = 1'b1;
      s_edges    = 0;
      s_prev_sck = sck8;
      s_cpha     = s_cfg_mode[0];
      s_tx       = s_cfg_tx;
      s_seq      = 8'h00;
      if (!s_cpha) begin
        miso8 = s_tx[7];
        s_tx  = s_tx << 1;
      end
    end else if (sck8 != s_prev_sck) begin
      s_prev_sck = sck8;
      s_edges    = s_edges + 1;
      if ((s_edges % 2 == 1) ^ s_cpha) begin
        s_seq = {s_seq[6:0], mosi8};
      end else begin
        miso8 = s_tx[7];
        s_tx  = s_tx << 1;
      end
    end
  end

  // Runs one transfer on dut8 and reports observations; callers do the checking.
  task automatic run_xfer8(input logic [7:0] din, input logic [1:0] md, input logic lsb,
                           input logic [1:0] cs, input logic [7:0] s_word, input bit poke,
                           output int lat, output logic [7:0] dout, output logic [7:0] seq,
                           output bit cs_err, output logic [1:0] csn_done,
                           output logic busy_after, output logic done_after,
                           output logic sck_after, output logic sck_setup);
    logic [1:0] exp_cs;
    exp_cs     = (cs == 2'd0) ? 2'b10 : 2'b01;
    s_cfg_tx   = s_word;
    s_cfg_mode = md;
    data_in8 = din; mode8 = md; lsb8 = lsb; cs_sel8 = cs; start8 = 1'b1;
    @(posedge clk); #1;
    start8    = 1'b0;
    sck_setup = sck8;
    lat = -1; cs_err = 1'b0; dout = 8'hxx; csn_done = 2'bxx;
    for (int n = 1; n <= 120; n++) begin
      @(posedge clk); #1;
      if (poke && n == 10) begin
        start8 = 1'b1; data_in8 = 8'hFF; mode8 = ~md; lsb8 = ~lsb; cs_sel8 = 2'd1;
      end
      if (poke && n == 11) start8 = 1'b0;
      if (done8) begin
        lat = n; dout = data_out8; csn_done = cs_n8;
        break;
      end
      if (cs_n8 !== exp_cs) cs_err = 1'b1;
    end
    @(posedge clk); #1;
    busy_after = busy8; done_after = done8; sck_after = sck8; seq = s_seq;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (cs_n8 !== 2'b11) begin bad++; $display("FAIL reset_cs_n: got %b want 11", cs_n8); end
    total++; if (sck8 !== 1'b0) begin bad++; $display("FAIL reset_sck: got %b want 0", sck8); end
    total++; if (mosi8 !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", mosi8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done8); end
    total++; if (data_out8 !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h want 00", data_out8); end
    total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL reset_busy16: got %b want 0", busy16); end
    rst = 1'b1;
    @(posedge clk); #1;
    $display("reset: cs_n=%b sck=%b busy=%b", cs_n8, sck8, busy8);
  endtask

  task automatic test_mode0;
    int lat; logic [7:0] dout, seq; bit cs_err; logic [1:0] csn_d;
    logic b_a, d_a, s_a, s_s;
    run_xfer8(8'hA5, MODE0, 1'b0, 2'd0, 8'h5A, 1'b0, lat, dout, seq, cs_err, csn_d, b_a, d_a, s_a, s_s);
    $display("mode0: lat=%0d data_out=%h slave_rx=%h", lat, dout, seq);
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL m0_idle_busy: got %b want 0", busy8); end
    total++; if (lat !== 36) begin bad++; $display("FAIL m0_latency: got %0d want 36", lat); end
    total++; if (dout !== 8'h5A) begin bad++; $display("FAIL m0_data_out: got %h want 5a", dout); end
    total++; if (seq !== 8'hA5) begin bad++; $display("FAIL m0_mosi_bits: got %h want a5", seq); end
    total++; if (cs_err !== 1'b0) begin bad++; $display("FAIL m0_cs_during: got err=%b want 0", cs_err); end
    total++; if (csn_d !== 2'b11) begin bad++; $display("FAIL m0_cs_at_done: got %b want 11", csn_d); end
    total++; if (d_a !== 1'b0) begin bad++; $display("FAIL m0_done_pulse: got %b want 0", d_a); end
    total++; if (b_a !== 1'b0) begin bad++; $display("FAIL m0_busy_after: got %b want 0", b_a); end
  endtask

  task automatic test_modes;
    int lat; logic [7:0] dout, seq; bit cs_err; logic [1:0] csn_d;
    logic b_a, d_a, s_a, s_s;
    logic [1:0] md;
    for (int m = 1; m <= 3; m++) begin
      md = 2'(m);
      run_xfer8(8'hA5, md, 1'b0, (m == 3) ? 2'd1 : 2'd0, 8'h5A, 1'b0,
                lat, dout, seq, cs_err, csn_d, b_a, d_a, s_a, s_s);
      $display("mode%0d: lat=%0d data_out=%h slave_rx=%h sck_idle=%b", m, lat, dout, seq, s_a);
      total++; if (dout !== 8'h5A) begin bad++; $display("FAIL mode%0d_data_out: got %h want 5a", m, dout); end
      total++; if (seq !== 8'hA5) begin bad++; $display("FAIL mode%0d_slave_rx: got %h want a5", m, seq); end
      total++; if (s_a !== md[1]) begin bad++; $display("FAIL mode%0d_sck_idle: got %b want %b", m, s_a, md[1]); end
      total++; if (s_s !== md[1]) begin bad++; $display("FAIL mode%0d_sck_setup: got %b want %b", m, s_s, md[1]); end
      total++; if (cs_err !== 1'b0) begin bad++; $display("FAIL mode%0d_cs_during: got err=%b want 0", m, cs_err); end
    end
  endtask

  task automatic test_lsb_first;
    int lat; logic [7:0] dout, seq; bit cs_err; logic [1:0] csn_d;
    logic b_a, d_a, s_a, s_s;
    run_xfer8(8'h3C, MODE0, 1'b1, 2'd0, 8'hC3, 1'b0, lat, dout, seq, cs_err, csn_d, b_a, d_a, s_a, s_s);
    $display("lsb 3c: data_out=%h mosi_order=%b", dout, seq);
    total++; if (seq !== 8'b0011_1100) begin bad++; $display("FAIL lsb_mosi_order: got %b want 00111100", seq); end
    total++; if (dout !== 8'hC3) begin bad++; $display("FAIL lsb_data_out: got %h want c3", dout); end
    // asymmetric word: first wire bit must be data bit 0, first received bit lands in bit 0
    run_xfer8(8'h01, MODE1, 1'b1, 2'd0, 8'h01, 1'b0, lat, dout, seq, cs_err, csn_d, b_a, d_a, s_a, s_s);
    $display("lsb 01: data_out=%h mosi_order=%b", dout, seq);
    total++; if (seq !== 8'h80) begin bad++; $display("FAIL lsb_asym_mosi: got %h want 80", seq); end
    total++; if (dout !== 8'h80) begin bad++; $display("FAIL lsb_asym_data_out: got %h want 80", dout); end
  endtask

  task automatic test_ignore_start;
    int lat; logic [7:0] dout, seq; bit cs_err; logic [1:0] csn_d;
    logic b_a, d_a, s_a, s_s;
    bit stray;
    run_xfer8(8'hA5, MODE0, 1'b0, 2'd0, 8'h5A, 1'b1, lat, dout, seq, cs_err, csn_d, b_a, d_a, s_a, s_s);
    $display("busy start: lat=%0d data_out=%h slave_rx=%h", lat, dout, seq);
    total++; if (lat !== 36) begin bad++; $display("FAIL busy_start_latency: got %0d want 36", lat); end
    total++; if (seq !== 8'hA5) begin bad++; $display("FAIL busy_start_slave_rx: got %h want a5", seq); end
    total++; if (dout !== 8'h5A) begin bad++; $display("FAIL busy_start_data_out: got %h want 5a", dout); end
    total++; if (cs_err !== 1'b0) begin bad++; $display("FAIL busy_start_cs: got err=%b want 0", cs_err); end
    for (int k = 2; k <= 3; k++) begin
      stray = 1'b0;
      cs_sel8 = 2'(k); start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (6) begin
        if (busy8 !== 1'b0 || cs_n8 !== 2'b11) stray = 1'b1;
        @(posedge clk); #1;
      end
      $display("cs_sel=%0d start: busy=%b cs_n=%b", k, busy8, cs_n8);
      total++; if (stray !== 1'b0) begin bad++; $display("FAIL bad_cs_sel%0d_ignored: got activity=%b want 0", k, stray); end
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [7:0] dout, seq; bit cs_err; logic [1:0] csn_d;
    logic b_a, d_a, s_a, s_s;
    int edges;
    logic prev;
    bit seen_done;
    s_cfg_tx = 8'h5A; s_cfg_mode = MODE0;
    data_in8 = 8'hA5; mode8 = MODE0; lsb8 = 1'b0; cs_sel8 = 2'd0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    edges = 0; prev = sck8;
    for (int n = 0; n < 100 && edges < 5; n++) begin
      @(posedge clk); #1;
      if (sck8 !== prev) begin edges++; prev = sck8; end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset mid: edges=%0d cs_n=%b sck=%b busy=%b", edges, cs_n8, sck8, busy8);
    total++; if (edges !== 5) begin bad++; $display("FAIL rmid_edges_seen: got %0d want 5", edges); end
    total++; if (cs_n8 !== 2'b11) begin bad++; $display("FAIL rmid_cs_n: got %b want 11", cs_n8); end
    total++; if (sck8 !== 1'b0) begin bad++; $display("FAIL rmid_sck: got %b want 0", sck8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy8); end
    rst = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done8 !== 1'b0) seen_done = 1'b1;
    end
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL rmid_no_done: got %b want 0", seen_done); end
    run_xfer8(8'h96, MODE0, 1'b0, 2'd0, 8'h69, 1'b0, lat, dout, seq, cs_err, csn_d, b_a, d_a, s_a, s_s);
    $display("after reset: data_out=%h slave_rx=%h", dout, seq);
    total++; if (dout !== 8'h69) begin bad++; $display("FAIL rmid_fresh_data_out: got %h want 69", dout); end
    total++; if (seq !== 8'h96) begin bad++; $display("FAIL rmid_fresh_slave_rx: got %h want 96", seq); end
  endtask

  task automatic test_wide_loopback;
    int lat;
    logic [15:0] dout;
    bit cs_err;
    data_in16 = 16'hBEEF; mode16 = MODE0; lsb16 = 1'b0; cs_sel16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = -1; dout = 16'hxxxx; cs_err = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done16) begin lat = n; dout = data_out16; break; end
      if (cs_n16 !== 2'b10) cs_err = 1'b1;
    end
    $display("wide loopback: lat=%0d data_out=%h", lat, dout);
    total++; if (lat !== 34) begin bad++; $display("FAIL wide_latency: got %0d want 34", lat); end
    total++; if (dout !== 16'hBEEF) begin bad++; $display("FAIL wide_data_out: got %h want beef", dout); end
    total++; if (cs_err !== 1'b0) begin bad++; $display("FAIL wide_cs_during: got err=%b want 0", cs_err); end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_modes;
    test_lsb_first;
    test_ignore_start;
    test_reset_mid;
    test_wide_loopback;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
